dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  MEM-stage data-memory sequencer. Accepts one load/store request from the pipeline and stalls the
//  pipeline while the access is in flight. Drives the dmem port with a word-aligned address, lane-shifted
//  store data and a byte mask from an internal mask_gen instance, then returns aligned and extended load data.
//  Detects misaligned accesses and memory timeouts and reports each without touching memory.
// PARAMETERS
//  TIMEOUT  default 64  ACCESS-state cycles without dmem_resp before bus error; 0 = never time out
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous reset, active-low
//  req_valid    in   1   MEM stage holds a load/store; held stable while stall=1
//  req_write    in   1   1=store, 0=load
//  req_funct3   in   3   RV32I load/store funct3
//  req_addr     in   32  effective address (ALU output)
//  req_wdata    in   32  store data (rs2), byte/half in low bits
//  stall        out  1   freeze pipeline
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_misalign out  1   with rsp_valid: misaligned or illegal funct3
//  rsp_bus_err  out  1   with rsp_valid: timeout
//  dmem_read    out  1   read strobe
//  dmem_write   out  1   write strobe
//  dmem_address out  32  {addr[31:2],2'b00}
//  dmem_wdata   out  32  req_wdata << 8*addr[1:0]
//  dmem_wmask   out  4   rv32i_mem_wmask from mask_gen
//  dmem_rdata   in   32  read data
//  dmem_resp    in   1   access complete
// BEHAVIOUR
//  - Async reset, any time including mid-access: state=IDLE, timeout counter=0, every output 0 at once.
//    The in-flight dmem transaction is abandoned.
//  - States: IDLE, ACCESS, DONE.
//  - IDLE, req_valid=0: stall=0 and nothing happens.
//  - IDLE, req_valid=1: stall=1 combinationally.
//    - Register addr, funct3, write, shifted wdata and mask.
//    - If aligned, go to ACCESS.
//    - Otherwise go to DONE with misalign set. This covers half with addr[0]=1, word with addr[1:0]!=0,
//      and funct3 not in {000,001,010,100,101}, or not in {000,001,010} for stores.
//  - ACCESS: stall=1. Exactly one of dmem_read/dmem_write=1.
//    - dmem_address, dmem_wdata and dmem_wmask come from registers and are stable until dmem_resp.
//    - dmem_resp=1: latch extended load data, drop strobes next cycle, go to DONE.
//    - TIMEOUT>0 and counter==TIMEOUT-1 without resp: go to DONE with bus_err=1 and rdata=0.
//  - DONE: stall=0, rsp_valid=1 for exactly one cycle, then IDLE unconditionally.
//    The req_valid seen in DONE is the retiring request and is not accepted.
//  - Latency: request accepted at cycle T, strobes asserted T+1..R where R is the dmem_resp cycle,
//    rsp_valid at R+1. Minimum stall is 2 cycles (T, T+1); a misaligned request stalls 1 cycle.
//  - dmem_resp outside ACCESS is ignored. The counter clears on entering ACCESS.
//  - Load data = dmem_rdata >> 8*addr[1:0], then extended:
//    000 sign-8, 100 zero-8, 001 sign-16, 101 zero-16, 010 full word.
//  - Mask: byte 0001<<addr[1:0]; half 0011/1100; word 1111; rsp fields registered, no comb path from dmem.
// STRUCTURE
//  - rv32i_types gains: typedef enum {IDLE,ACCESS,DONE} dmem_state_t.
//    Also gains funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
//  - Instantiate existing mask_gen for dmem_wmask.
//  - One new sub-module: load_extend (funct3, addr[1:0], rdata -> rv32i_word), purely combinational.
//  - FSM, registers and timeout counter stay in this module.
// TESTING
//  1 LW addr=0x100, dmem_resp after 3 cycles, rdata=0xDEADBEEF -> wmask=1111, addr=0x100, rsp_rdata=0xDEADBEEF;
//    stall high 4 cycles, rsp_valid 1 cycle.
//  2 SB addr=0x103 wdata=0x000000AB -> dmem_write=1, wmask=1000, wdata=0xAB000000, address=0x100, rsp_rdata=0.
//  3 LB addr=0x102 and LHU addr=0x102 with rdata=0x80FF1234 -> 0xFFFFFFFF and 0x000080FF.
//  4 LH addr=0x101 and SW addr=0x102 -> no dmem strobe, rsp_misalign=1, stall exactly 1 cycle each.
//  5 TIMEOUT=8, no dmem_resp -> strobe for 8 cycles, then rsp_bus_err=1, rsp_rdata=0, returns to IDLE.
//  6 rst_n low during ACCESS -> strobes/stall drop same cycle; a new LW after release completes normally;
//    back-to-back requests each accepted once.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared RV32I types, load/store funct3 codes and alignment check
package dmem_access_ctrl_pkg;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_t;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a, input logic wr);
    return !(f3 inside {LB, LH, LW} || (!wr && f3 inside {LBU, LHU}))
        || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_access_ctrl_load_extend.sv
// load_extend: lane-align raw read data and sign/zero extend it by funct3
module load_extend
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  rv32i_word  rdata,
  output rv32i_word  data
);
  rv32i_word sh;
  assign sh = rdata >> {addr_lo, 3'b000};
  assign data = funct3 == LB  ? {{24{sh[7]}}, sh[7:0]}
              : funct3 == LBU ? {24'b0, sh[7:0]}
              : funct3 == LH  ? {{16{sh[15]}}, sh[15:0]}
              : funct3 == LHU ? {16'b0, sh[15:0]} : sh;
endmodule

// File: rtl/dmem_access_ctrl_mask_gen.sv
// mask_gen: byte-lane mask for a byte, half or word access at the given offset
module mask_gen (
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] rv32i_mem_wmask
);
  assign rv32i_mem_wmask = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo
                         : funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011)
                         : funct3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer issuing one data-memory access per request with stall and timeout
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        rsp_bus_err,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  dmem_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0] f3_q;
  logic [3:0] mask_q, mask;
  logic wr_q, mis_q, err_q, bad, tmo, accept;
  rv32i_word ext;
  mask_gen u_mask (.funct3(req_funct3), .addr_lo(req_addr[1:0]), .rv32i_mem_wmask(mask));
  load_extend u_ext (.funct3(f3_q), .addr_lo(addr_q[1:0]), .rdata(dmem_rdata), .data(ext));
  assign bad = misaligned(req_funct3, req_addr[1:0], req_write);
  assign tmo = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1);
  assign accept = state == IDLE && req_valid;
  assign dmem_address = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wmask = mask_q;
  assign rsp_rdata = state == DONE ? rdata_q : '0;
  assign rsp_misalign = state == DONE && mis_q;
  assign rsp_bus_err = state == DONE && err_q;
  // state register; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state and handshake outputs; stall is forced low while reset is held
  always_comb begin
    state_n = state;
    stall = 1'b0;
    rsp_valid = 1'b0;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid && rst_n;
        state_n = req_valid ? (bad ? DONE : ACCESS) : IDLE;
      end
      ACCESS: begin
        stall = 1'b1;
        dmem_read = !wr_q;
        dmem_write = wr_q;
        state_n = dmem_resp || tmo ? DONE : ACCESS;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // request capture, response latching and the ACCESS cycle counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q <= '0;
      mask_q <= '0;
      wr_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      if (accept) begin
        addr_q <= req_addr;
        f3_q <= req_funct3;
        wr_q <= req_write;
        wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
        mask_q <= mask;
        mis_q <= bad;
        err_q <= 1'b0;
        rdata_q <= '0;
      end
      if (state == ACCESS && dmem_resp) rdata_q <= wr_q ? '0 : ext;
      else if (state == ACCESS && tmo) err_q <= 1'b1;
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: table-driven scoreboard bench for the data-memory sequencer
module tb_dmem_access_ctrl;
  logic clk = 0, rst_n = 1;
  logic req_valid = 0, req_write = 0, dmem_resp = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, dmem_rdata = 0;
  logic stall, rsp_valid, rsp_misalign, rsp_bus_err, dmem_read, dmem_write;
  logic [31:0] rsp_rdata, dmem_address, dmem_wdata;
  logic [3:0] dmem_wmask;
  int tests = 0, fails = 0;
  typedef struct {
    logic wr; logic [2:0] f3; logic [31:0] addr, wdata, mrdata; int dly;
    logic [31:0] e_rdata; logic e_mis, e_err; logic [3:0] e_mask; logic [31:0] e_wdata; int e_stall, e_strb;
  } vec_t;
  typedef struct {logic [31:0] rdata; logic mis, err;} rsp_t;
  rsp_t q[$];
  vec_t vt[12];

  dmem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misalign(rsp_misalign), .rsp_bus_err(rsp_bus_err), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(negedge clk)
    if (rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
      else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_misalign", 32'(rsp_misalign), 32'(e.mis));
        chk("rsp_bus_err", 32'(rsp_bus_err), 32'(e.err));
      end
    end

  task automatic run(input vec_t v);
    int st, sb, cyc;
    logic done;
    st = 0; sb = 0; cyc = 0; done = 0;
    @(posedge clk); #1;
    req_valid = 1; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    dmem_rdata = v.mrdata;
    q.push_back('{v.e_rdata, v.e_mis, v.e_err});
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stall) st++;
      if (dmem_read || dmem_write) begin
        sb++;
        chk("strobe_kind", 32'({dmem_write, dmem_read}), v.wr ? 32'd2 : 32'd1);
        chk("dmem_address", dmem_address, {v.addr[31:2], 2'b00});
        chk("dmem_wmask", 32'(dmem_wmask), 32'(v.e_mask));
        chk("dmem_wdata", dmem_wdata, v.e_wdata);
        dmem_resp = (sb == v.dly);
      end else dmem_resp = 0;
      done = rsp_valid;
    end
    dmem_resp = 0;
    chk("rsp_seen", 32'(done), 32'(1));
    chk("stall_cycles", 32'(st), 32'(v.e_stall));
    chk("strobe_cycles", 32'(sb), 32'(v.e_strb));
  endtask

  initial begin
    vt[0]  = '{0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 0, 0, 4'b1111, 0, 4, 3};
    vt[1]  = '{1, 3'b000, 32'h103, 32'hAB, 0, 1, 0, 0, 0, 4'b1000, 32'hAB000000, 2, 1};
    vt[2]  = '{0, 3'b000, 32'h102, 0, 32'h80FF1234, 2, 32'hFFFFFFFF, 0, 0, 4'b0100, 0, 3, 2};
    vt[3]  = '{0, 3'b101, 32'h102, 0, 32'h80FF1234, 1, 32'h000080FF, 0, 0, 4'b1100, 0, 2, 1};
    vt[4]  = '{0, 3'b001, 32'h101, 0, 0, 1, 0, 1, 0, 4'b0000, 0, 1, 0};
    vt[5]  = '{1, 3'b010, 32'h102, 32'h11223344, 0, 1, 0, 1, 0, 4'b0000, 0, 1, 0};
    vt[6]  = '{1, 3'b001, 32'h202, 32'h1234, 0, 1, 0, 0, 0, 4'b1100, 32'h12340000, 2, 1};
    vt[7]  = '{0, 3'b100, 32'h201, 0, 32'h00009A00, 2, 32'h0000009A, 0, 0, 4'b0010, 0, 3, 2};
    vt[8]  = '{0, 3'b011, 32'h200, 0, 0, 1, 0, 1, 0, 4'b0000, 0, 1, 0};
    vt[9]  = '{1, 3'b100, 32'h200, 32'h55, 0, 1, 0, 1, 0, 4'b0000, 0, 1, 0};
    vt[10] = '{0, 3'b010, 32'h300, 0, 32'h12345678, 0, 0, 0, 1, 4'b1111, 0, 9, 8};
    vt[11] = '{0, 3'b001, 32'h10A, 0, 32'h8001FFFF, 1, 32'hFFFF8001, 0, 0, 4'b1100, 0, 2, 1};
    #2 rst_n = 0;
    req_valid = 1;
    #1;
    chk("reset_stall", 32'(stall), 32'(0));
    chk("reset_strobes", 32'({dmem_read, dmem_write, rsp_valid}), 32'(0));
    chk("reset_address", dmem_address, 32'(0));
    chk("reset_rsp", 32'({rsp_rdata, rsp_misalign, rsp_bus_err}), 32'(0));
    req_valid = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk); dmem_resp = 1;
    @(negedge clk); dmem_resp = 0;
    chk("idle_resp_ignored", 32'({stall, dmem_read, dmem_write}), 32'(0));
    foreach (vt[i]) run(vt[i]);
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1;
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h400;
    repeat (3) @(negedge clk);
    chk("pre_reset_read", 32'({stall, dmem_read}), 32'(3));
    rst_n = 0;
    #1;
    chk("mid_reset_outputs", 32'({stall, dmem_read, dmem_write, rsp_valid}), 32'(0));
    chk("mid_reset_wmask", 32'(dmem_wmask), 32'(0));
    req_valid = 0;
    @(negedge clk); rst_n = 1;
    run(vt[0]);
    run(vt[3]);
    @(posedge clk); #1 req_valid = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
